// File: rtl/data_mem_responder.sv
// Multi-cycle 16-bit data memory responder: in-order responses a fixed LATENCY after accept.
// Define MEM_PIPELINE_EN for a fully pipelined build; otherwise a single-outstanding IDLE/BUSY FSM gates req_ready.
module data_mem_responder #(
  parameter int DEPTH_W = 15,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [15:0] rsp_addr,
  output logic [15:0] rsp_data
);

  localparam int WORDS = 1 << DEPTH_W;

  logic [15:0]        mem [WORDS];
  logic               accept;
  logic [DEPTH_W-1:0] word_idx;

  logic [LATENCY-1:0] valid_pipe;
  logic [LATENCY-1:0] wr_pipe;
  logic [15:0]        addr_pipe [LATENCY];
  logic [15:0]        data_pipe [LATENCY];

  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[DEPTH_W:1];

  // Storage is deliberately outside the reset so committed writes survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      mem[word_idx] <= req_data;
    end
  end

  // Stage 0 samples the array on the accepting edge; idle stages carry zeros so outputs read 0 when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      wr_pipe    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_pipe[i] <= '0;
        data_pipe[i] <= '0;
      end
    end else begin
      valid_pipe[0] <= accept;
      wr_pipe[0]    <= accept & req_wr;
      addr_pipe[0]  <= accept ? req_addr : '0;
      data_pipe[0]  <= (accept && !req_wr) ? mem[word_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        wr_pipe[i]    <= wr_pipe[i-1];
        addr_pipe[i]  <= addr_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign rsp_valid = valid_pipe[LATENCY-1];
  assign rsp_wr    = wr_pipe[LATENCY-1];
  assign rsp_addr  = addr_pipe[LATENCY-1];
  assign rsp_data  = data_pipe[LATENCY-1];

`ifdef MEM_PIPELINE_EN
  assign req_ready = 1'b1;
`else
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Leaving BUSY on the edge the count hits zero lines req_ready up with rsp_valid.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (LATENCY > 1)) begin
          state_next = BUSY;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed test-plan steps plus random traffic against a queue-based reference model.
module tb_data_mem_responder;
  localparam int DW  = 4;
  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [15:0] rsp_addr;
  logic [15:0] rsp_data;

  data_mem_responder #(.DEPTH_W(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_addr(rsp_addr), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          due;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } rsp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_acc = -1000;
  rsp_t        exp_q[$];
  logic [15:0] mem_m [1 << DW];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic model_ready();
`ifdef MEM_PIPELINE_EN
    return 1'b1;
`else
    return (cyc >= last_acc + LAT);
`endif
  endfunction

  task automatic check_outputs(input logic exp_rdy);
    rsp_t e;
    e = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rsp_valid", {15'b0, rsp_valid}, 16'd1);
    end else begin
      chk("rsp_valid", {15'b0, rsp_valid}, 16'd0);
    end
    chk("req_ready", {15'b0, req_ready}, {15'b0, exp_rdy});
    chk("rsp_wr", {15'b0, rsp_wr}, {15'b0, e.wr});
    chk("rsp_addr", rsp_addr, e.addr);
    chk("rsp_data", rsp_data, e.data);
  endtask

  // One clock cycle: drive, check this cycle's outputs, clock, update the model.
  task automatic step(input logic v, input logic w, input logic [15:0] a,
                      input logic [15:0] d, output logic acc);
    logic        exp_rdy;
    logic [15:0] a_v;
    rsp_t        r;
    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_data  = d;
    #1;
    exp_rdy = model_ready();
    check_outputs(exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    if (acc) begin
      a_v    = a;
      r.due  = cyc + LAT;
      r.wr   = w;
      r.addr = a;
      r.data = w ? 16'h0000 : mem_m[a_v[DW:1]];
      if (w) mem_m[a_v[DW:1]] = d;
      exp_q.push_back(r);
      last_acc = cyc;
      $display("[TB] cyc=%0d accept %s addr=%h data=%h", cyc, w ? "WR" : "RD", a, w ? d : r.data);
    end
    cyc++;
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, w, a, d, acc);
      n++;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {15'b0, req_ready}, 16'd1);
    chk({tag, "_valid"}, {15'b0, rsp_valid}, 16'd0);
    chk({tag, "_wr"}, {15'b0, rsp_wr}, 16'd0);
    chk({tag, "_addr"}, rsp_addr, 16'h0000);
    chk({tag, "_data"}, rsp_data, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = 16'h0;
    req_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Preload every word so nothing reads uninitialised storage.
    for (int i = 0; i < (1 << DW); i++) issue(1'b1, 16'(i * 2), 16'($urandom));

    // Write then read back, echoed address and write ack.
    issue(1'b1, 16'h0010, 16'hBEEF);
    issue(1'b0, 16'h0010, 16'h0);
    idle(LAT + 2);

    // Back-to-back reads of 1,2,3,4.
    issue(1'b1, 16'h0000, 16'd1);
    issue(1'b1, 16'h0002, 16'd2);
    issue(1'b1, 16'h0004, 16'd3);
    issue(1'b1, 16'h0006, 16'd4);
    idle(LAT);
    issue(1'b0, 16'h0000, 16'h0);
    issue(1'b0, 16'h0002, 16'h0);
    issue(1'b0, 16'h0004, 16'h0);
    issue(1'b0, 16'h0006, 16'h0);
    idle(LAT + 2);

    // Read ordered before a write to the same word returns the old value.
    issue(1'b1, 16'h0020, 16'h1111);
    idle(LAT);
    issue(1'b0, 16'h0020, 16'h0);
    issue(1'b1, 16'h0020, 16'h2222);
    issue(1'b0, 16'h0020, 16'h0);
    idle(LAT + 2);

    // Odd byte address and modulo wrap onto word 0.
    issue(1'b1, 16'h0021, 16'hA5A5);
    issue(1'b0, 16'h0000, 16'h0);
    issue(1'b0, 16'h0020, 16'h0);
    issue(1'b0, 16'hFFE0, 16'h0);
    idle(LAT + 2);

    // Reset two cycles after a read accept discards it; storage survives.
    issue(1'b0, 16'h0010, 16'h0);
    idle(2);
    rst_n = 1'b0;
    exp_q.delete();
    last_acc = -1000;
    #1;
    check_reset_outputs("midrst");
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_reset_outputs("inrst");
    rst_n = 1'b1;
    idle(LAT + 2);
    issue(1'b0, 16'h0010, 16'h0);
    idle(LAT + 2);

    // Random traffic, including dropped valids and out-of-range upper address bits.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 2 == 1, 16'($urandom), 16'($urandom), acc);
    end
    idle(LAT + 2);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
